// File: rtl/led_seq_mux.sv
// Purpose : LED bar driver that muxes score sources, blinks them or animates a walking LED.
// Latency : leds_out is registered, so input changes show one clock later; tick_out is combinational.
// Backpressure: none; the block is free-running and accepts new inputs every cycle.
module led_seq_mux #(
    parameter int              LED_W     = 7,
    parameter int              N_SRC     = 4,
    parameter int              TICK_DIV  = 25000000,
    parameter logic [LED_W-1:0] RESET_PAT = 7'b1001000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               mode,
    input  logic [$clog2(N_SRC)-1:0] src_sel,
    input  logic [N_SRC*LED_W-1:0]   src_bus,
    output logic [LED_W-1:0]         leds_out,
    output logic                     tick_out
);

    localparam int PW = $clog2(LED_W);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0] POS_MAX = PW'(LED_W - 1);

    typedef enum logic [2:0] {
        M_OFF    = 3'd0,
        M_RESET  = 3'd1,
        M_ALL_ON = 3'd2,
        M_SHOW   = 3'd3,
        M_BLINK  = 3'd4,
        M_CHASE  = 3'd5,
        M_BOUNCE = 3'd6,
        M_RSVD   = 3'd7
    } mode_t;

    mode_t             cur_mode;
    mode_t             mode_q;
    logic [CW-1:0]     cnt;
    logic              phase;
    logic [PW-1:0]     pos;
    logic              dir_down;

    logic              mode_chg;
    logic              at_wrap;
    logic              tick;
    logic [CW-1:0]     n_cnt;
    logic              n_phase;
    logic [PW-1:0]     n_pos;
    logic              n_down;
    logic [LED_W-1:0]  n_leds;
    logic [LED_W-1:0]  sel_src;
    logic [LED_W-1:0]  src_arr [N_SRC];

    assign cur_mode = mode_t'(mode);

    // Unpack the flat source bus so the active source is a plain array lookup.
    always_comb begin
        for (int k = 0; k < N_SRC; k++) begin
            src_arr[k] = src_bus[k*LED_W +: LED_W];
        end
    end

    assign sel_src  = src_arr[src_sel];

    // A mode change restarts the animation, so a tick coinciding with it is dropped.
    assign mode_chg = (cur_mode != mode_q);
    assign at_wrap  = (cnt == CNT_MAX);
    assign tick     = at_wrap && !mode_chg;
    assign tick_out = tick;

    // Next-state for prescaler and animation state, plus the LED pattern derived from it.
    always_comb begin
        n_cnt   = at_wrap ? '0 : cnt + 1'b1;
        n_phase = phase;
        n_pos   = pos;
        n_down  = dir_down;
        if (mode_chg) begin
            n_cnt   = '0;
            n_phase = 1'b1;
            n_pos   = '0;
            n_down  = 1'b0;
        end else if (tick) begin
            case (cur_mode)
                M_BLINK: n_phase = ~phase;
                M_CHASE: n_pos   = (pos == POS_MAX) ? '0 : pos + 1'b1;
                M_BOUNCE: begin
                    // Endpoints reverse immediately so neither end is held for two ticks.
                    if (!dir_down) begin
                        if (pos == POS_MAX) begin
                            n_down = 1'b1;
                            n_pos  = pos - 1'b1;
                        end else begin
                            n_pos  = pos + 1'b1;
                        end
                    end else begin
                        if (pos == '0) begin
                            n_down = 1'b0;
                            n_pos  = pos + 1'b1;
                        end else begin
                            n_pos  = pos - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        case (cur_mode)
            M_OFF:    n_leds = '0;
            M_RESET:  n_leds = RESET_PAT;
            M_ALL_ON: n_leds = '1;
            M_SHOW:   n_leds = sel_src;
            M_BLINK:  n_leds = n_phase ? sel_src : '0;
            M_CHASE:  n_leds = LED_W'(1) << n_pos;
            M_BOUNCE: n_leds = LED_W'(1) << n_pos;
            M_RSVD:   n_leds = '0;
            default:  n_leds = '0;
        endcase
    end

    // State and LED output registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= M_OFF;
            cnt      <= '0;
            phase    <= 1'b1;
            pos      <= '0;
            dir_down <= 1'b0;
            leds_out <= '0;
        end else begin
            mode_q   <= cur_mode;
            cnt      <= n_cnt;
            phase    <= n_phase;
            pos      <= n_pos;
            dir_down <= n_down;
            leds_out <= n_leds;
        end
    end

endmodule
